// File: rtl/conv_mac_sequencer_if.sv
// Handshake and product-mux bus between the 3x3 MAC sequencer, the product mux and the pixel writer.
// master: the sequencer itself; slave: the surrounding mux / writer environment.
interface conv_mac_sequencer_if #(
  parameter int unsigned WIDTH     = 14,
  parameter int unsigned ACC_WIDTH = 18
) ();

  logic                        prod_valid;
  logic                        prod_ready;
  logic [3:0]                  mux_sel;
  logic signed [WIDTH-1:0]     in_adder;
  logic                        in_adder_valid;
  logic signed [ACC_WIDTH-1:0] res;
  logic                        res_valid;
  logic                        res_ready;
  logic                        busy;
  logic [15:0]                 win_cnt;

  modport master (
    input  prod_valid,
    input  in_adder,
    input  in_adder_valid,
    input  res_ready,
    output prod_ready,
    output mux_sel,
    output res,
    output res_valid,
    output busy,
    output win_cnt
  );

  modport slave (
    output prod_valid,
    output in_adder,
    output in_adder_valid,
    output res_ready,
    input  prod_ready,
    input  mux_sel,
    input  res,
    input  res_valid,
    input  busy,
    input  win_cnt
  );

endinterface

// File: rtl/conv_mac_sequencer.sv
// Steps the product mux through nine terms, accumulates them and returns the sum via valid/ready.
// Optional CONV_SEQ_CLAMP_EN clamps the result to [0, OUT_MAX] before it is loaded into res.
module conv_mac_sequencer #(
  parameter int unsigned WIDTH     = 14,
  parameter int unsigned ACC_WIDTH = 18,
  parameter int unsigned OUT_MAX   = 255
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  conv_mac_sequencer_if.master        bus_io
);

  // Nine terms need four guard bits; the clamp bound must be representable as a positive sum.
  if (ACC_WIDTH < WIDTH + 4) begin : g_bad_acc_width
    $error("ACC_WIDTH must be at least WIDTH+4");
  end
  if (OUT_MAX >= (32'd1 << (ACC_WIDTH - 1))) begin : g_bad_out_max
    $error("OUT_MAX does not fit in a positive ACC_WIDTH value");
  end

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } state_e;

  localparam logic [3:0] SelLast = 4'd8;
  localparam logic [3:0] SelNone = 4'd9;

  state_e                      state_q;
  logic [3:0]                  mux_sel_q;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] res_q;
  logic                        res_valid_q;
  logic [15:0]                 win_cnt_q;

  logic signed [ACC_WIDTH-1:0] term_ext;
  logic signed [ACC_WIDTH-1:0] sum_full;
  logic signed [ACC_WIDTH-1:0] sum_out;
  logic                        prod_ready;
  logic                        prod_hs;

  assign term_ext = {{(ACC_WIDTH - WIDTH){bus_io.in_adder[WIDTH-1]}}, bus_io.in_adder};
  assign sum_full = acc_q + term_ext;

`ifdef CONV_SEQ_CLAMP_EN
  localparam logic signed [ACC_WIDTH-1:0] OutMaxS = ACC_WIDTH'(OUT_MAX);

  always_comb begin
    sum_out = sum_full;
    if (sum_full[ACC_WIDTH-1]) begin
      sum_out = '0;
    end else if (sum_full > OutMaxS) begin
      sum_out = OutMaxS;
    end
  end
`else
  assign sum_out = sum_full;
`endif

  // Ready is forced low during reset so no window can be accepted in that cycle.
  always_comb begin
    prod_ready = 1'b0;
    case (state_q)
      StIdle:  prod_ready = 1'b1;
      StDone:  prod_ready = bus_io.res_ready;
      default: prod_ready = 1'b0;
    endcase
    if (rst_i) begin
      prod_ready = 1'b0;
    end
  end

  assign prod_hs = bus_io.prod_valid && prod_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      mux_sel_q   <= SelNone;
      acc_q       <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      win_cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (prod_hs) begin
            acc_q     <= '0;
            mux_sel_q <= '0;
            state_q   <= StAccum;
          end
        end
        StAccum: begin
          if (bus_io.in_adder_valid) begin
            acc_q <= sum_full;
            if (mux_sel_q == SelLast) begin
              res_q       <= sum_out;
              res_valid_q <= 1'b1;
              mux_sel_q   <= SelNone;
              state_q     <= StDone;
            end else begin
              mux_sel_q <= mux_sel_q + 4'd1;
            end
          end
        end
        StDone: begin
          if (res_valid_q && bus_io.res_ready) begin
            res_valid_q <= 1'b0;
            win_cnt_q   <= win_cnt_q + 16'd1;
            // Bypass straight into the next window so back-to-back windows need no idle cycle.
            if (bus_io.prod_valid) begin
              acc_q     <= '0;
              mux_sel_q <= '0;
              state_q   <= StAccum;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: begin
          state_q   <= StIdle;
          mux_sel_q <= SelNone;
        end
      endcase
    end
  end

  assign bus_io.prod_ready = prod_ready;
  assign bus_io.mux_sel    = mux_sel_q;
  assign bus_io.res        = res_q;
  assign bus_io.res_valid  = res_valid_q;
  assign bus_io.busy       = (state_q != StIdle);
  assign bus_io.win_cnt    = win_cnt_q;

  a_sel_range: assert property (@(posedge clk_i) disable iff (rst_i) mux_sel_q <= SelNone);

  a_res_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (res_valid_q && !bus_io.res_ready) |=> (res_valid_q && $stable(res_q)));

  a_idle_sel: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == StIdle) |-> (mux_sel_q == SelNone));

endmodule

// File: doc/conv_mac_sequencer.md
# conv_mac_sequencer

Sequencer and accumulator for the 3x3 convolution MAC path. The block accepts a window of nine products already presented on the product mux. It steps the mux select 0..8 one term per cycle and accumulates the selected term into a signed running sum. It then returns the finished convolution result through a valid/ready handshake. It sits between the multiplier bank / product mux and the output pixel writer.

## Interface
- WIDTH, 14: signed product width; must match the product mux width.
- ACC_WIDTH, 18: signed accumulator and result width; must be at least WIDTH+4.
- OUT_MAX, 255: upper clamp bound, used only when the clamp feature is compiled in.

- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- prod_valid  in  1  all nine products of a window are stable on the mux inputs.
- prod_ready  out  1  block can start a new window.
- mux_sel  out  4  select driven to the product mux.
- in_adder  in  WIDTH  signed term from the product mux.
- in_adder_valid  in  1  mux term valid flag.
- res  out  ACC_WIDTH  signed convolution result.
- res_valid  out  1  res holds a completed window.
- res_ready  in  1  downstream accepts res.
- busy  out  1  state is not IDLE.
- win_cnt  out  16  count of completed result handshakes.

## Operation
- FSM states are IDLE, ACCUM and DONE.
- **IDLE**
  - mux_sel = 9, so the mux flags its output invalid.
  - prod_ready = 1.
  - On prod_valid && prod_ready: acc <= 0, mux_sel <= 0, go to ACCUM.
- **ACCUM**
  - Each cycle with in_adder_valid = 1: acc <= acc + sign_extend(in_adder), and mux_sel increments.
  - If in_adder_valid = 0: acc and mux_sel hold (stall), and no term is lost.
  - When the term at mux_sel = 8 is accumulated: res <= final sum (after optional clamp), res_valid <= 1, mux_sel <= 9, go to DONE.
  - prod_ready = 0 throughout ACCUM.
- **DONE**
  - res and res_valid hold until res_ready = 1.
  - On res_valid && res_ready, win_cnt increments, wrapping 0xFFFF -> 0.
  - The exit state depends on prod_valid in that same cycle:
    - If prod_valid = 1, go directly to ACCUM (acc <= 0, mux_sel <= 0, res_valid <= 0).
    - Otherwise go to IDLE with res_valid <= 0.
  - prod_ready = res_ready while in DONE.
- **Arithmetic**
  - Two's-complement; no overflow is possible for nine terms when ACC_WIDTH >= WIDTH+4.
  - res is taken from acc plus the final term in the same cycle.
- Products must stay stable from the prod handshake until res_valid rises; the block does not latch them.

## Timing
- Reset values:
  - State IDLE.
  - mux_sel = 9.
  - acc = 0, res = 0, res_valid = 0, win_cnt = 0, busy = 0.
  - prod_ready = 0 while rst is high, and 1 on the first cycle after rst falls.
- Latency with no stalls:
  - Handshake at edge T.
  - mux_sel = 0..8 during cycles T+1..T+9.
  - res_valid = 1 after edge T+9.
  - Each stall cycle adds one cycle.
- Throughput: one window per 10 cycles with prod_valid and res_ready held high, using the DONE->ACCUM bypass.
- Reset asserted mid-ACCUM or in DONE: the window is abandoned, no res_valid is produced, win_cnt is cleared, and everything returns to reset values on the next edge.
- prod_valid asserted during ACCUM is ignored, since prod_ready = 0.

## Configuration
- Macro: CONV_SEQ_CLAMP_EN.
- Defined: the final sum is clamped to [0, OUT_MAX] before loading res.
  - Negative sums give 0.
  - Sums above OUT_MAX give OUT_MAX.
  - res is zero-extended to ACC_WIDTH.
- Undefined: res is the full signed ACC_WIDTH sum, unmodified.
- Handshake and timing are identical in both builds.

## Test plan
- Products 100,200..900, prod_valid pulse, res_ready = 1:
  - mux_sel sequence 9,0,1..8,9.
  - res = 4500 unclamped, or 255 with CONV_SEQ_CLAMP_EN.
  - res_valid high for 1 cycle, 10 cycles after the handshake; win_cnt = 1.
- All products = -8192:
  - res = -73728 without clamp, 0 with clamp.
- Backpressure: hold res_ready = 0 for 5 cycles after res_valid:
  - res stable and res_valid high throughout.
  - prod_ready = 0 throughout.
  - Handshake completes on the cycle res_ready rises.
- Back-to-back: three windows with prod_valid and res_ready held at 1 (sums 4500, 45, -45 unclamped):
  - Results appear at 10-cycle spacing with no IDLE cycle between windows.
  - win_cnt = 3.
- Stall: force in_adder_valid = 0 for 2 cycles while mux_sel = 4:
  - mux_sel holds at 4.
  - Result is still 4500, with latency 12.
- Reset mid-window: assert rst for 1 cycle while mux_sel = 5:
  - No res_valid appears.
  - mux_sel = 9, win_cnt = 0, prod_ready = 1 the cycle after rst falls.
  - A following window returns the correct result.
